// File: rtl/mem_log_mc_if.sv
// Bus bundle for the multi-channel capture logger: capture controls, sample
// stream, read-back request and status/read-data outputs.
interface mem_log_mc_if #(
    parameter int BRAM_ADDR_WIDTH = 15,
    parameter int BRAM_DATA_WIDTH = 16,
    parameter int N_CH            = 2,
    parameter int DEC_WIDTH       = 8
);
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [N_CH*BRAM_DATA_WIDTH-1:0] i_filter_data;
    logic                            i_valid;
    logic                            i_run_log;
    logic                            i_stop_log;
    logic                            i_mode;
    logic [DEC_WIDTH-1:0]            i_decim;
    logic                            i_read_log;
    logic [CH_W-1:0]                 i_ch_sel;
    logic [BRAM_ADDR_WIDTH-1:0]      i_addr_log_to_mem;
    logic                            o_mem_full;
    logic                            o_busy;
    logic [BRAM_ADDR_WIDTH:0]        o_log_count;
    logic [BRAM_ADDR_WIDTH-1:0]      o_start_addr;
    logic [BRAM_DATA_WIDTH-1:0]      o_data_log_from_mem;

    // Host/filter side drives the requests and samples the results.
    modport master (
        output i_filter_data, i_valid, i_run_log, i_stop_log, i_mode, i_decim,
               i_read_log, i_ch_sel, i_addr_log_to_mem,
        input  o_mem_full, o_busy, o_log_count, o_start_addr, o_data_log_from_mem
    );

    // Logger side.
    modport slave (
        input  i_filter_data, i_valid, i_run_log, i_stop_log, i_mode, i_decim,
               i_read_log, i_ch_sel, i_addr_log_to_mem,
        output o_mem_full, o_busy, o_log_count, o_start_addr, o_data_log_from_mem
    );
endinterface

// File: rtl/mem_log_mc.sv
// Multi-channel BRAM capture logger. Stores N_CH filter streams in lock-step,
// in one-shot or circular (pre-trigger) mode with decimation, and reads back
// by logical address where address 0 is always the oldest stored sample.
module mem_log_mc #(
    parameter int BRAM_ADDR_WIDTH = 15,
    parameter int BRAM_DATA_WIDTH = 16,
    parameter int N_CH            = 2,
    parameter int DEC_WIDTH       = 8
) (
    input logic         clk,
    input logic         i_rst,
    mem_log_mc_if.slave bus
);
    localparam int AW   = BRAM_ADDR_WIDTH;
    localparam int DW   = BRAM_DATA_WIDTH;
    localparam int CW   = AW + 1;
    localparam int D    = 2 ** AW;
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, FULL} state_t;

    state_t               state_q;
    logic                 mode_q;
    logic [DEC_WIDTH-1:0] decim_q;
    logic [DEC_WIDTH-1:0] dcnt_q;
    logic [AW-1:0]        wptr_q;
    logic                 wrap_q;
    logic                 full_q;
    logic                 busy_q;
    logic [CW-1:0]        count_q;
    logic [AW-1:0]        start_q;
    logic [DW-1:0]        rdata_q;

    logic [DW-1:0] mem [N_CH][D];

    logic                 we_d;
    logic                 last_addr_d;
    logic [AW-1:0]        wptr_inc_d;
    logic [AW-1:0]        wptr_d;
    logic [CW-1:0]        count_d;
    logic [DEC_WIDTH-1:0] dcnt_d;
    logic [AW-1:0]        phys_d;
    logic [DW-1:0]        rd_mux_d;

    // A restart pulse takes priority over any write in the same cycle.
    assign we_d        = (state_q == RUN) && !bus.i_run_log && bus.i_valid && (dcnt_q == '0);
    assign last_addr_d = &wptr_q;
    assign wptr_inc_d  = wptr_q + AW'(1);
    assign wptr_d      = we_d ? wptr_inc_d : wptr_q;
    assign count_d     = {1'b0, wptr_q} + CW'(we_d);
    assign dcnt_d      = (dcnt_q == decim_q) ? '0 : dcnt_q + DEC_WIDTH'(1);
    assign phys_d      = bus.i_addr_log_to_mem + start_q;

    // Capture FSM: arm/restart, pointer and decimation bookkeeping, termination.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            mode_q  <= 1'b0;
            decim_q <= '0;
            dcnt_q  <= '0;
            wptr_q  <= '0;
            wrap_q  <= 1'b0;
            full_q  <= 1'b0;
            busy_q  <= 1'b0;
            count_q <= '0;
            start_q <= '0;
        end else if (bus.i_run_log) begin
            state_q <= RUN;
            mode_q  <= bus.i_mode;
            decim_q <= bus.i_decim;
            dcnt_q  <= '0;
            wptr_q  <= '0;
            wrap_q  <= 1'b0;
            full_q  <= 1'b0;
            busy_q  <= 1'b1;
            count_q <= '0;
            start_q <= '0;
        end else if (state_q == RUN) begin
            if (bus.i_valid) begin
                dcnt_q <= dcnt_d;
            end
            if (we_d) begin
                wptr_q <= wptr_inc_d;
                if (last_addr_d) begin
                    wrap_q <= 1'b1;
                end
            end
            if (!mode_q && we_d && last_addr_d) begin
                state_q <= FULL;
                full_q  <= 1'b1;
                busy_q  <= 1'b0;
                count_q <= CW'(D);
                start_q <= '0;
            end else if (bus.i_stop_log) begin
                state_q <= FULL;
                full_q  <= 1'b1;
                busy_q  <= 1'b0;
                // Once wrapped, the next write slot holds the oldest sample.
                if (mode_q && (wrap_q || (we_d && last_addr_d))) begin
                    count_q <= CW'(D);
                    start_q <= wptr_d;
                end else begin
                    count_q <= count_d;
                    start_q <= '0;
                end
            end
        end
    end

    // Sample storage, all channels written at the same physical address.
    always_ff @(posedge clk) begin
        if (we_d) begin
            for (int k = 0; k < N_CH; k++) begin
                mem[k][wptr_q] <= bus.i_filter_data[k*DW +: DW];
            end
        end
    end

    // Channel select; out-of-range selects fall through to zero.
    always_comb begin
        rd_mux_d = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (bus.i_ch_sel == CH_W'(k)) begin
                rd_mux_d = mem[k][phys_d];
            end
        end
    end

    // Registered read-back; forced to zero while a capture is running.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            rdata_q <= '0;
        end else if (state_q == RUN) begin
            rdata_q <= '0;
        end else if (bus.i_read_log) begin
            rdata_q <= rd_mux_d;
        end
    end

    assign bus.o_mem_full          = full_q;
    assign bus.o_busy              = busy_q;
    assign bus.o_log_count         = count_q;
    assign bus.o_start_addr        = start_q;
    assign bus.o_data_log_from_mem = rdata_q;
endmodule
